// File: rtl/dvp_apb_pkg.sv
// Shared DVP APB definitions: FSM encoding, bus width, register map.
package dvp_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int DVP_APB_ADDR_W = 3;

  localparam logic [DVP_APB_ADDR_W-1:0] DI_CR    = 3'd0;
  localparam logic [DVP_APB_ADDR_W-1:0] DI_START = 3'd1;
  localparam logic [DVP_APB_ADDR_W-1:0] DI_END   = 3'd2;
  localparam logic [DVP_APB_ADDR_W-1:0] DP_CR    = 3'd3;
  localparam logic [DVP_APB_ADDR_W-1:0] DO_CR    = 3'd4;

endpackage

// File: rtl/dvp_apb_watchdog.sv
// ACCESS-phase cycle counter; flags the TIMEOUT-th stalled ACCESS cycle.
module dvp_apb_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // cnt_q holds the number of ACCESS cycles already completed
  assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dvp_apb_master.sv
// Single-outstanding APB initiator for the DVP register slaves.
// Optional ACCESS watchdog enabled by DVP_APB_MASTER_TIMEOUT_EN.
module dvp_apb_master
  import dvp_apb_pkg::*;
#(
  parameter int ADDR_W  = DVP_APB_ADDR_W,
  parameter int NSLV    = 1,
  parameter int SEL_W   = 1,
  parameter int TIMEOUT = 256
) (
  input  logic              io_ahb_PCLK,
  input  logic              io_ahb_PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] io_ahb_PADDR,
  output logic [NSLV-1:0]   io_ahb_PSEL,
  output logic              io_ahb_PENABLE,
  output logic              io_ahb_PWRITE,
  output logic [31:0]       io_ahb_PWDATA,
  input  logic              io_ahb_PREADY,
  input  logic [31:0]       io_ahb_PRDATA,
  input  logic              io_ahb_PSLVERROR
);

  localparam logic [NSLV-1:0] SEL_ONE = NSLV'(1);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [NSLV-1:0]   psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              cmd_fire;
  logic              sel_ok;
  logic              wd_expired;

`ifdef DVP_APB_MASTER_TIMEOUT_EN
  dvp_apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (io_ahb_PCLK),
    .rst     (io_ahb_PRESET),
    .clr     (state_q == ST_SETUP),
    .run     (state_q == ST_ACCESS),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_expired     = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign sel_ok    = 32'(cmd_sel) < 32'(NSLV);

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_q && rsp_ready)
      rsp_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_fire && sel_ok) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          psel_d   = SEL_ONE << cmd_sel;
          state_d  = ST_SETUP;
        end else if (cmd_fire) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (io_ahb_PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : io_ahb_PRDATA;
          rsp_err_d   = io_ahb_PSLVERROR;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (wd_expired) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge io_ahb_PCLK or posedge io_ahb_PRESET) begin
    if (io_ahb_PRESET) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign io_ahb_PADDR   = paddr_q;
  assign io_ahb_PSEL    = psel_q;
  assign io_ahb_PENABLE = penable_q;
  assign io_ahb_PWRITE  = pwrite_q;
  assign io_ahb_PWDATA  = pwdata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

endmodule
